// File: rtl/ac_pkg.sv
// Shared types and constants for the arithmetic-coder bit emission path.
package ac_pkg;

    localparam int unsigned BOUND_W = 16;
    localparam int unsigned PEND_W  = 5;
    localparam int unsigned LEN_W   = $clog2(BOUND_W) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PEND,
        ST_REST,
        ST_PAD
    } emit_state_t;

    typedef struct packed {
        logic [BOUND_W-1:0] prefix_bits;
        logic [LEN_W-1:0]   prefix_len;
        logic [PEND_W-1:0]  underflow_cnt;
        logic               flush;
    } ac_pkt_t;

    // Saturating add of the pending accumulator; MSB of the result flags saturation.
    function automatic logic [PEND_W:0] pend_sat_add(input logic [PEND_W-1:0] a,
                                                     input logic [PEND_W-1:0] b);
        logic [PEND_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[PEND_W]) begin
            return {1'b1, {PEND_W{1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/ac_bit_packer.sv
// Serial bit-in / word-out packer: MSB-first shift register, one-word holding
// register on a valid/ready stream, zero padding and last-word marking.
module ac_bit_packer #(
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld_i,
    input  logic             bit_i,
    input  logic             pad_i,
    output logic             stall_o,
    output logic             bit_ack_o,
    output logic             pad_done_o,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    localparam int unsigned CNT_W = $clog2(OUT_W + 1);

    logic [OUT_W-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] m_data_q;
    logic             m_valid_q;
    logic             m_last_q;

    logic             take;
    logic             free;
    logic             word_full;
    logic [OUT_W-1:0] word_d;
    logic [OUT_W-1:0] pad_word;

    // Holding-register availability, stall and word assembly.
    always_comb begin
        take       = m_valid_q && m_ready;
        free       = !m_valid_q || m_ready;
        word_full  = (cnt_q == CNT_W'(OUT_W - 1));
        stall_o    = bit_vld_i && word_full && !free;
        bit_ack_o  = bit_vld_i && !stall_o;
        pad_done_o = pad_i && (free || (cnt_q == '0));
        word_d     = {sr_q[OUT_W-2:0], bit_i};
        pad_word   = sr_q << (OUT_W - 32'(cnt_q));
    end

    // Shift in accepted bits, hand full or padded words to the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            if (take) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            if (bit_ack_o) begin
                if (word_full) begin
                    m_data_q  <= word_d;
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b0;
                    sr_q      <= '0;
                    cnt_q     <= '0;
                end else begin
                    sr_q  <= word_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (pad_done_o) begin
                if (cnt_q != '0) begin
                    m_data_q  <= pad_word;
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b1;
                    sr_q      <= '0;
                    cnt_q     <= '0;
                end else if (!free) begin
                    // Nothing partial: the word still waiting downstream becomes the last one.
                    m_last_q <= 1'b1;
                end else begin
                    m_data_q  <= '0;
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b1;
                end
            end
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

endmodule

// File: rtl/ac_bit_emitter.sv
// Arithmetic-coder bit emitter: resolved prefix bits interleaved with pending
// (E3) bits, packed MSB-first into words.
// Optional statistics counters: define AC_BIT_EMITTER_STATS_EN.
module ac_bit_emitter
    import ac_pkg::*;
#(
    parameter int unsigned BOUND_W = ac_pkg::BOUND_W,
    parameter int unsigned PEND_W  = ac_pkg::PEND_W,
    parameter int unsigned OUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BOUND_W-1:0]         prefix_bits,
    input  logic [$clog2(BOUND_W):0]   prefix_len,
    input  logic [PEND_W-1:0]          underflow_cnt,
    input  logic                       flush,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       pend_ovf
`ifdef AC_BIT_EMITTER_STATS_EN
    ,
    output logic [31:0]                bits_emitted,
    output logic [31:0]                words_emitted
`endif
);

    emit_state_t       state_q;
    ac_pkt_t           pkt_q;
    ac_pkt_t           in_pkt;
    logic [PEND_W-1:0] pend_q;
    logic              ovf_q;
    logic              head_bit_q;

    logic [PEND_W-1:0] acc_base;
    logic [PEND_W-1:0] acc_uf;
    logic [PEND_W:0]   acc_res;
    logic              bit_vld;
    logic              bit_val;
    logic              pad_req;
    logic              stall;
    logic              bit_ack;
    logic              pad_done;

    // Input packet view, accumulate operands and the bit offered to the packer.
    always_comb begin
        in_pkt.prefix_bits   = prefix_bits;
        in_pkt.prefix_len    = prefix_len;
        in_pkt.underflow_cnt = underflow_cnt;
        in_pkt.flush         = flush;
        // A packet with no resolved bits accumulates straight from the accept cycle;
        // otherwise the accumulator has already drained to zero when the packet ends.
        acc_base = (state_q == ST_IDLE) ? pend_q : '0;
        acc_uf   = (state_q == ST_IDLE) ? underflow_cnt : pkt_q.underflow_cnt;
        acc_res  = pend_sat_add(acc_base, acc_uf);
        bit_vld  = (state_q == ST_HEAD) || (state_q == ST_PEND) || (state_q == ST_REST);
        bit_val  = (state_q == ST_PEND) ? ~head_bit_q : pkt_q.prefix_bits[BOUND_W-1];
        pad_req  = (state_q == ST_PAD);
    end

    // Emission FSM: head bit, pending inverted bits, remaining prefix, optional pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pkt_q      <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            head_bit_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        pkt_q <= in_pkt;
                        if (prefix_len != '0) begin
                            state_q <= ST_HEAD;
                        end else begin
                            pend_q  <= acc_res[PEND_W-1:0];
                            ovf_q   <= ovf_q | acc_res[PEND_W];
                            state_q <= flush ? ST_PAD : ST_IDLE;
                        end
                    end
                end
                ST_HEAD: begin
                    if (bit_ack) begin
                        head_bit_q        <= pkt_q.prefix_bits[BOUND_W-1];
                        pkt_q.prefix_bits <= pkt_q.prefix_bits << 1;
                        pkt_q.prefix_len  <= pkt_q.prefix_len - 1'b1;
                        if (pend_q != '0) begin
                            state_q <= ST_PEND;
                        end else if (pkt_q.prefix_len > 1) begin
                            state_q <= ST_REST;
                        end else begin
                            pend_q  <= acc_res[PEND_W-1:0];
                            ovf_q   <= ovf_q | acc_res[PEND_W];
                            state_q <= pkt_q.flush ? ST_PAD : ST_IDLE;
                        end
                    end
                end
                ST_PEND: begin
                    if (bit_ack) begin
                        pend_q <= pend_q - 1'b1;
                        if (pend_q == 1) begin
                            if (pkt_q.prefix_len != '0) begin
                                state_q <= ST_REST;
                            end else begin
                                pend_q  <= acc_res[PEND_W-1:0];
                                ovf_q   <= ovf_q | acc_res[PEND_W];
                                state_q <= pkt_q.flush ? ST_PAD : ST_IDLE;
                            end
                        end
                    end
                end
                ST_REST: begin
                    if (bit_ack) begin
                        pkt_q.prefix_bits <= pkt_q.prefix_bits << 1;
                        pkt_q.prefix_len  <= pkt_q.prefix_len - 1'b1;
                        if (pkt_q.prefix_len == 1) begin
                            pend_q  <= acc_res[PEND_W-1:0];
                            ovf_q   <= ovf_q | acc_res[PEND_W];
                            state_q <= pkt_q.flush ? ST_PAD : ST_IDLE;
                        end
                    end
                end
                ST_PAD: begin
                    if (pad_done) begin
                        pend_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready  = (state_q == ST_IDLE);
    assign pend_ovf = ovf_q;

    ac_bit_packer #(
        .OUT_W (OUT_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .bit_vld_i  (bit_vld),
        .bit_i      (bit_val),
        .pad_i      (pad_req),
        .stall_o    (stall),
        .bit_ack_o  (bit_ack),
        .pad_done_o (pad_done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

`ifdef AC_BIT_EMITTER_STATS_EN
    logic [31:0] bits_q;
    logic [31:0] words_q;

    // Emitted-bit and handshaken-word counters, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q  <= '0;
            words_q <= '0;
        end else begin
            if (bit_ack) begin
                bits_q <= bits_q + 1'b1;
            end
            if (m_valid && m_ready) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

    assign bits_emitted  = bits_q;
    assign words_emitted = words_q;
`endif

    // stall is consumed inside the packer's bit_ack; kept visible for debug.
    logic unused_stall;
    assign unused_stall = stall;

endmodule

// File: tb/tb_ac_bit_emitter.sv
// Directed bench for ac_bit_emitter.
module tb_ac_bit_emitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] prefix_bits;
    logic [4:0]  prefix_len;
    logic [4:0]  underflow_cnt;
    logic        flush;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        pend_ovf;
`ifdef AC_BIT_EMITTER_STATS_EN
    logic [31:0] bits_emitted;
    logic [31:0] words_emitted;
`endif

    int checks   = 0;
    int failures = 0;

    logic [8:0] words[$];

    ac_bit_emitter #(
        .BOUND_W (16),
        .PEND_W  (5),
        .OUT_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .prefix_bits   (prefix_bits),
        .prefix_len    (prefix_len),
        .underflow_cnt (underflow_cnt),
        .flush         (flush),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .pend_ovf      (pend_ovf)
`ifdef AC_BIT_EMITTER_STATS_EN
        ,
        .bits_emitted  (bits_emitted),
        .words_emitted (words_emitted)
`endif
    );

    always #5 clk = ~clk;

    // Record every output handshake as {last, data}; inputs change only at posedge+1.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            words.push_back({m_last, m_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (s_ready !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic send(input logic [15:0] bits, input logic [4:0] len,
                        input logic [4:0] uf, input logic fl);
        wait_ready("s_ready_timeout");
        prefix_bits   = bits;
        prefix_len    = len;
        underflow_cnt = uf;
        flush         = fl;
        s_valid       = 1'b1;
        cyc(1);
        s_valid       = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic wait_idle();
        wait_ready("idle_timeout");
        cyc(3);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        cyc(2);
        rst = 1'b0;
        words.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        s_valid       = 1'b0;
        m_ready       = 1'b1;
        prefix_bits   = '0;
        prefix_len    = '0;
        underflow_cnt = '0;
        flush         = 1'b0;
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_pend_ovf", 32'(pend_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // Packing: A{len0,uf2} B{101} C{011} -> 1 000 1 011 = 0x8B
        send(16'h0000, 5'd0, 5'd2, 1'b0);
        send(16'hA000, 5'd3, 5'd0, 1'b0);
        send(16'h6000, 5'd3, 5'd0, 1'b0);
        wait_idle();
        chk("pack_count", 32'(words.size()), 32'd1);
        chk("pack_word", 32'(words[0]), 32'h08B);

        // Flush {01}: pending must be 0, so 01 + pad -> 0x40 last
        send(16'h4000, 5'd2, 5'd0, 1'b1);
        wait_idle();
        chk("flush_count", 32'(words.size()), 32'd2);
        chk("flush_word", 32'(words[1]), 32'h140);
        chk("flush_s_ready", 32'(s_ready), 32'd1);
        cyc(5);
        chk("flush_no_extra", 32'(words.size()), 32'd2);

        // Flush with one pending bit: 1,0 padded -> 0x80 last
        do_reset();
        send(16'h0000, 5'd0, 5'd1, 1'b0);
        send(16'h8000, 5'd1, 5'd0, 1'b1);
        wait_idle();
        chk("fpend_count", 32'(words.size()), 32'd1);
        chk("fpend_word", 32'(words[0]), 32'h180);

        // Backpressure: 8 packets of "10" fill one held word and stall on bit 16
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(16'h8000, 5'd2, 5'd0, 1'b0);
        end
        cyc(10);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h0AA);
        chk("bp_s_ready_low", 32'(s_ready), 32'd0);
        chk("bp_no_handshake", 32'(words.size()), 32'd0);
        cyc(5);
        chk("bp_m_data_stable", 32'(m_data), 32'h0AA);
        chk("bp_m_last_low", 32'(m_last), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(16'h8000, 5'd2, 5'd0, 1'b0);
        end
        wait_idle();
        chk("bp_count", 32'(words.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_word%0d", i), 32'(words[i]), 32'h0AA);
        end

        // Saturation: 31 then +1 saturates at 31 with sticky overflow
        do_reset();
        send(16'h0000, 5'd0, 5'd31, 1'b0);
        cyc(1);
        chk("sat_no_ovf_at_max", 32'(pend_ovf), 32'd0);
        send(16'h0000, 5'd0, 5'd1, 1'b0);
        cyc(1);
        chk("sat_ovf_set", 32'(pend_ovf), 32'd1);
        send(16'h0000, 5'd0, 5'd3, 1'b0);
        cyc(1);
        chk("sat_ovf_sticky", 32'(pend_ovf), 32'd1);
        // {11,flush}: 1, 31 zeros, 1 -> 80 00 00 00, then 1 padded -> 0x80 last
        send(16'hC000, 5'd2, 5'd0, 1'b1);
        wait_idle();
        chk("sat_count", 32'(words.size()), 32'd5);
        chk("sat_word0", 32'(words[0]), 32'h080);
        chk("sat_word1", 32'(words[1]), 32'h000);
        chk("sat_word3", 32'(words[3]), 32'h000);
        chk("sat_word4", 32'(words[4]), 32'h180);
        chk("sat_ovf_after_flush", 32'(pend_ovf), 32'd1);

        // Reset while in PEND with a held word
        do_reset();
        m_ready = 1'b0;
        send(16'hAA00, 5'd8, 5'd0, 1'b0);
        send(16'h0000, 5'd0, 5'd5, 1'b0);
        send(16'h8000, 5'd1, 5'd0, 1'b0);
        cyc(2);
        chk("mid_pre_m_valid", 32'(m_valid), 32'd1);
        chk("mid_pre_busy", 32'(s_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_m_valid", 32'(m_valid), 32'd0);
        chk("mid_m_data", 32'(m_data), 32'd0);
        chk("mid_m_last", 32'(m_last), 32'd0);
        chk("mid_s_ready", 32'(s_ready), 32'd1);
        cyc(2);
        rst = 1'b0;
        words.delete();
        m_ready = 1'b1;
        send(16'hC000, 5'd4, 5'd0, 1'b1);
        wait_idle();
        chk("post_rst_count", 32'(words.size()), 32'd1);
        chk("post_rst_word", 32'(words[0]), 32'h1C0);

        // Flush with nothing partial and nothing held -> 0x00 last
        send(16'h0000, 5'd0, 5'd0, 1'b1);
        wait_idle();
        chk("empty_flush_count", 32'(words.size()), 32'd2);
        chk("empty_flush_word", 32'(words[1]), 32'h100);
`ifdef AC_BIT_EMITTER_STATS_EN
        chk("stats_bits", bits_emitted, 32'd4);
        chk("stats_words", words_emitted, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
